// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: owns the CSR file port, passes core accesses through
// while idle, and runs the trap / mret CSR sequence ending in a one-cycle PC redirect.
module trap_ctrl #(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_reset,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_valid,
  input  logic        irq_msip,
  input  logic        irq_mtip,
  input  logic        irq_meip,
  input  logic [31:0] irq_pc,
  input  logic [11:0] core_csr_addr,
  input  logic [31:0] core_csr_wdata,
  input  logic        core_csr_wen,
  output logic [31:0] core_csr_rdata,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic        csr_wen,
  input  logic [31:0] csr_rdata,
  input  logic        ctrl_mie,
  input  logic        ctrl_mpie,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTAT, R_MTVEC, M_STAT, R_MEPC
  } state_t;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  state_t      state;
  logic [3:0]  cause_q;
  logic        irq_q;
  logic [31:2] pc_q;
  logic [31:0] tval_q;
  logic [2:0]  mie_shadow;   // {MEIE, MTIE, MSIE}

  logic [2:0]  irq_hit;
  logic        irq_req;
  logic [3:0]  irq_cause;
  logic        core_wr_mie;
  logic [31:0] mstat_trap;
  logic [31:0] mstat_mret;
  logic [31:0] tvec_base;
  logic        vec_mode;
  logic [31:0] trap_target;
  logic [31:0] mepc_target;
  logic [11:0] addr_c;
  logic [31:0] wdata_c;
  logic        wen_c;

  // Low PC bits are always cleared when written to mepc; MPIE is already in csr_rdata.
  logic unused_ok;
  assign unused_ok = ^{ctrl_mpie, exc_pc[1:0], irq_pc[1:0]};

  assign irq_hit     = {irq_meip, irq_mtip, irq_msip} & mie_shadow;
  assign irq_req     = ctrl_mie & (|irq_hit);
  assign core_wr_mie = (state == IDLE) && core_csr_wen && (core_csr_addr == ADDR_MIE);
  assign busy        = (state != IDLE);

  always_comb begin
    irq_cause = 4'd7;
    if (irq_hit[2])      irq_cause = 4'd11;
    else if (irq_hit[0]) irq_cause = 4'd3;
  end

  always_comb begin
    mstat_trap    = csr_rdata;
    mstat_trap[7] = csr_rdata[3];
    mstat_trap[3] = 1'b0;
    mstat_mret    = csr_rdata;
    mstat_mret[3] = csr_rdata[7];
    mstat_mret[7] = 1'b1;
  end

  assign tvec_base   = {csr_rdata[31:2], 2'b00};
  assign vec_mode    = VECTORED_EN && (csr_rdata[1:0] == 2'b01) && irq_q;
  assign trap_target = vec_mode ? (tvec_base + {26'd0, cause_q, 2'b00}) : tvec_base;
  assign mepc_target = {csr_rdata[31:2], 2'b00};

  // CSR port mux: the core owns the port only while idle.
  always_comb begin
    addr_c         = 12'h000;
    wdata_c        = 32'h0;
    wen_c          = 1'b0;
    core_csr_rdata = 32'h0;
    case (state)
      IDLE: begin
        addr_c         = core_csr_addr;
        wdata_c        = core_csr_wdata;
        wen_c          = core_csr_wen;
        core_csr_rdata = csr_rdata;
      end
      W_MEPC: begin
        addr_c  = ADDR_MEPC;
        wdata_c = {pc_q, 2'b00};
        wen_c   = 1'b1;
      end
      W_MCAUSE: begin
        addr_c  = ADDR_MCAUSE;
        wdata_c = {irq_q, 27'd0, cause_q};
        wen_c   = 1'b1;
      end
      W_MTVAL: begin
        addr_c  = ADDR_MTVAL;
        wdata_c = tval_q;
        wen_c   = 1'b1;
      end
      W_MSTAT: begin
        addr_c  = ADDR_MSTATUS;
        wdata_c = mstat_trap;
        wen_c   = 1'b1;
      end
      R_MTVEC: addr_c = ADDR_MTVEC;
      M_STAT: begin
        addr_c  = ADDR_MSTATUS;
        wdata_c = mstat_mret;
        wen_c   = 1'b1;
      end
      R_MEPC:  addr_c = ADDR_MEPC;
      default: ;
    endcase
  end

  assign csr_addr  = addr_c;
  assign csr_wdata = wdata_c;
  assign csr_wen   = wen_c & ~ctrl_reset;

  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state          <= IDLE;
      cause_q        <= 4'd0;
      irq_q          <= 1'b0;
      pc_q           <= 30'd0;
      tval_q         <= 32'h0;
      mie_shadow     <= 3'b000;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
    end else begin
      redirect_valid <= 1'b0;
      if (core_wr_mie)
        mie_shadow <= {core_csr_wdata[11], core_csr_wdata[7], core_csr_wdata[3]};
      case (state)
        // Acceptance sees the shadow as it was before any same-cycle mie write.
        IDLE: begin
          if (exc_valid) begin
            cause_q <= exc_cause;
            irq_q   <= 1'b0;
            pc_q    <= exc_pc[31:2];
            tval_q  <= exc_tval;
            state   <= W_MEPC;
          end else if (irq_req) begin
            cause_q <= irq_cause;
            irq_q   <= 1'b1;
            pc_q    <= irq_pc[31:2];
            tval_q  <= 32'h0;
            state   <= W_MEPC;
          end else if (mret_valid) begin
            state <= M_STAT;
          end
        end
        W_MEPC:   state <= W_MCAUSE;
        W_MCAUSE: state <= W_MTVAL;
        W_MTVAL:  state <= W_MSTAT;
        W_MSTAT:  state <= R_MTVEC;
        R_MTVEC: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= trap_target;
          state          <= IDLE;
        end
        M_STAT:   state <= R_MEPC;
        R_MEPC: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= mepc_target;
          state          <= IDLE;
        end
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a behavioural CSR file, a table of trap/mret
// scenarios, and hand-written sequences for masking, port ownership and reset abort.
module tb_trap_ctrl;

  logic        ctrl_clk;
  logic        ctrl_reset;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret_valid;
  logic        irq_msip;
  logic        irq_mtip;
  logic        irq_meip;
  logic [31:0] irq_pc;
  logic [11:0] core_csr_addr;
  logic [31:0] core_csr_wdata;
  logic        core_csr_wen;
  logic [31:0] core_csr_rdata;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic [31:0] csr_rdata;
  logic        ctrl_mie;
  logic        ctrl_mpie;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  trap_ctrl #(.VECTORED_EN(1'b1)) dut (
    .ctrl_clk       (ctrl_clk),
    .ctrl_reset     (ctrl_reset),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .exc_tval       (exc_tval),
    .mret_valid     (mret_valid),
    .irq_msip       (irq_msip),
    .irq_mtip       (irq_mtip),
    .irq_meip       (irq_meip),
    .irq_pc         (irq_pc),
    .core_csr_addr  (core_csr_addr),
    .core_csr_wdata (core_csr_wdata),
    .core_csr_wen   (core_csr_wen),
    .core_csr_rdata (core_csr_rdata),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_wen        (csr_wen),
    .csr_rdata      (csr_rdata),
    .ctrl_mie       (ctrl_mie),
    .ctrl_mpie      (ctrl_mpie),
    .busy           (busy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial ctrl_clk = 1'b0;
  always #5 ctrl_clk = ~ctrl_clk;

  // Behavioural CSR file; it is not reset, so aborted sequences leave partial updates.
  logic [31:0] m_status, m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval;

  always @(posedge ctrl_clk) begin
    if (csr_wen) begin
      case (csr_addr)
        12'h300: m_status  <= csr_wdata;
        12'h304: m_ie      <= csr_wdata;
        12'h305: m_tvec    <= csr_wdata;
        12'h340: m_scratch <= csr_wdata;
        12'h341: m_epc     <= csr_wdata;
        12'h342: m_cause   <= csr_wdata;
        12'h343: m_tval    <= csr_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      12'h300: csr_rdata = m_status;
      12'h304: csr_rdata = m_ie;
      12'h305: csr_rdata = m_tvec;
      12'h340: csr_rdata = m_scratch;
      12'h341: csr_rdata = m_epc;
      12'h342: csr_rdata = m_cause;
      12'h343: csr_rdata = m_tval;
      default: csr_rdata = 32'h0;
    endcase
  end

  assign ctrl_mie  = m_status[3];
  assign ctrl_mpie = m_status[7];

  typedef struct {
    logic        exc;
    logic [3:0]  cause;
    logic [31:0] pc;
    logic [31:0] tval;
    logic [2:0]  lines;   // {meip, mtip, msip}
    logic [31:0] ipc;
    logic        mret;
    logic [31:0] mie;
    logic [31:0] mstat;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] e_mepc;
    logic [31:0] e_mcause;
    logic [31:0] e_mtval;
    logic [31:0] e_mstat;
    logic [31:0] e_rpc;
    int          e_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic coreWrite(input logic [11:0] addr, input logic [31:0] data);
    @(negedge ctrl_clk);
    core_csr_addr  = addr;
    core_csr_wdata = data;
    core_csr_wen   = 1'b1;
    @(negedge ctrl_clk);
    core_csr_wen   = 1'b0;
  endtask

  task automatic waitRedirect(output int lat);
    lat = 1;
    while (!redirect_valid && lat < 20) begin
      @(negedge ctrl_clk);
      lat++;
    end
  endtask

  // Preload the CSR file through the passthrough port, raise the request, then
  // check timing, target and the CSR values the sequence left behind.
  task automatic applyStimulus(input vec_t v, input string tag);
    int lat;
    logic seen;
    coreWrite(12'h304, v.mie);
    coreWrite(12'h300, v.mstat);
    coreWrite(12'h305, v.mtvec);
    coreWrite(12'h341, v.mepc);
    exc_valid  = v.exc;
    exc_cause  = v.cause;
    exc_pc     = v.pc;
    exc_tval   = v.tval;
    mret_valid = v.mret;
    {irq_meip, irq_mtip, irq_msip} = v.lines;
    irq_pc     = v.ipc;
    @(posedge ctrl_clk);
    @(negedge ctrl_clk);
    checkOutput({tag, ".busy_t1"}, {31'd0, busy}, 32'd1);
    exc_valid  = 1'b0;
    mret_valid = 1'b0;
    waitRedirect(lat);
    checkOutput({tag, ".latency"}, lat, v.e_lat);
    checkOutput({tag, ".redirect_pc"}, redirect_pc, v.e_rpc);
    checkOutput({tag, ".busy_at_redirect"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, ".mepc"}, m_epc, v.e_mepc);
    checkOutput({tag, ".mcause"}, m_cause, v.e_mcause);
    checkOutput({tag, ".mtval"}, m_tval, v.e_mtval);
    checkOutput({tag, ".mstatus"}, m_status, v.e_mstat);
    seen = 1'b0;
    repeat (3) begin
      @(negedge ctrl_clk);
      seen = seen | busy | redirect_valid;
    end
    checkOutput({tag, ".no_retake"}, {31'd0, seen}, 32'd0);
    {irq_meip, irq_mtip, irq_msip} = 3'b000;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    logic seen;
    vec_t rv;

    //         exc cause  pc            tval          lines   ipc         mret  mie         mstat        mtvec         mepc        e_mepc        e_mcause      e_mtval       e_mstat       e_rpc         lat
    vecs[0]  = '{1'b1, 4'd2,  32'h104,      32'hDEADBEEF, 3'b000, 32'h0,    1'b0, 32'h0,   32'h8,    32'h200,      32'h0,    32'h104,      32'h2,        32'hDEADBEEF, 32'h80,   32'h200,      6};
    vecs[1]  = '{1'b0, 4'd0,  32'h0,        32'h0,        3'b010, 32'h4002, 1'b0, 32'h80,  32'h8,    32'h301,      32'h0,    32'h4000,     32'h80000007, 32'h0,        32'h80,   32'h31C,      6};
    vecs[2]  = '{1'b0, 4'd0,  32'h0,        32'h0,        3'b000, 32'h0,    1'b1, 32'h0,   32'h80,   32'h301,      32'h104,  32'h104,      32'h80000007, 32'h0,        32'h88,   32'h104,      3};
    vecs[3]  = '{1'b1, 4'd8,  32'h208,      32'h55,       3'b100, 32'h0,    1'b0, 32'h800, 32'h8,    32'h301,      32'h0,    32'h208,      32'h8,        32'h55,       32'h80,   32'h300,      6};
    vecs[4]  = '{1'b0, 4'd0,  32'h0,        32'h0,        3'b111, 32'h500,  1'b0, 32'h888, 32'h8,    32'h1001,     32'h0,    32'h500,      32'h8000000B, 32'h0,        32'h80,   32'h102C,     6};
    vecs[5]  = '{1'b0, 4'd0,  32'h0,        32'h0,        3'b011, 32'h600,  1'b0, 32'h88,  32'h8,    32'h1001,     32'h0,    32'h600,      32'h80000003, 32'h0,        32'h80,   32'h100C,     6};
    vecs[6]  = '{1'b0, 4'd0,  32'h0,        32'h0,        3'b100, 32'h700,  1'b0, 32'h800, 32'h8,    32'hFFFFFFF1, 32'h0,    32'h700,      32'h8000000B, 32'h0,        32'h80,   32'h1C,       6};
    vecs[7]  = '{1'b1, 4'd15, 32'hFFFFFFFF, 32'h12345678, 3'b000, 32'h0,    1'b0, 32'h0,   32'h8,    32'h1001,     32'h0,    32'hFFFFFFFC, 32'hF,        32'h12345678, 32'h80,   32'h1000,     6};
    vecs[8]  = '{1'b0, 4'd0,  32'h0,        32'h0,        3'b000, 32'h0,    1'b1, 32'h0,   32'h0,    32'h1001,     32'h2003, 32'h2003,     32'hF,        32'h12345678, 32'h80,   32'h2000,     3};
    vecs[9]  = '{1'b1, 4'd4,  32'h300,      32'h0,        3'b000, 32'h0,    1'b0, 32'h0,   32'h1888, 32'h200,      32'h0,    32'h300,      32'h4,        32'h0,        32'h1880, 32'h200,      6};
    vecs[10] = '{1'b1, 4'd1,  32'h10,       32'h7,        3'b000, 32'h0,    1'b0, 32'h0,   32'h80,   32'h200,      32'h0,    32'h10,       32'h1,        32'h7,        32'h0,    32'h200,      6};

    exc_valid = 1'b0; exc_cause = 4'd0; exc_pc = 32'h0; exc_tval = 32'h0;
    mret_valid = 1'b0; irq_msip = 1'b0; irq_mtip = 1'b0; irq_meip = 1'b0; irq_pc = 32'h0;
    core_csr_addr = 12'h340; core_csr_wdata = 32'h5A5A5A5A; core_csr_wen = 1'b1;

    // Reset state, with a core write pending that must not reach the CSR file.
    ctrl_reset = 1'b1;
    repeat (2) @(posedge ctrl_clk);
    @(negedge ctrl_clk);
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);
    checkOutput("reset.redirect_valid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("reset.redirect_pc", redirect_pc, 32'h0);
    checkOutput("reset.csr_wen", {31'd0, csr_wen}, 32'd0);
    core_csr_wen = 1'b0;
    ctrl_reset   = 1'b0;

    // Idle passthrough of core writes and reads.
    coreWrite(12'h340, 32'h1111);
    coreWrite(12'h305, 32'h200);
    core_csr_addr = 12'h305;
    #1;
    checkOutput("pass.rdata", core_csr_rdata, 32'h200);
    checkOutput("pass.addr", {20'd0, csr_addr}, 32'h305);
    checkOutput("pass.scratch", m_scratch, 32'h1111);

    for (int i = 0; i < 11; i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Masked interrupt stays pending until mie is written; port belongs to the sequencer while busy.
    coreWrite(12'h304, 32'h0);
    coreWrite(12'h300, 32'h8);
    coreWrite(12'h305, 32'h200);
    irq_meip = 1'b1;
    irq_pc   = 32'h800;
    seen = 1'b0;
    repeat (4) begin
      @(negedge ctrl_clk);
      seen = seen | busy;
    end
    checkOutput("mask.no_trap", {31'd0, seen}, 32'd0);
    core_csr_addr  = 12'h304;
    core_csr_wdata = 32'h800;
    core_csr_wen   = 1'b1;
    @(negedge ctrl_clk);
    core_csr_wen = 1'b0;
    checkOutput("mask.accept_cycle_idle", {31'd0, busy}, 32'd0);
    @(negedge ctrl_clk);
    checkOutput("mask.busy_next", {31'd0, busy}, 32'd1);
    core_csr_addr  = 12'h340;
    core_csr_wdata = 32'hAAAA;
    core_csr_wen   = 1'b1;
    #1;
    checkOutput("busy.core_rdata", core_csr_rdata, 32'h0);
    @(negedge ctrl_clk);
    core_csr_wen = 1'b0;
    waitRedirect(lat);
    checkOutput("mask.redirect_seen", {31'd0, redirect_valid}, 32'd1);
    checkOutput("mask.redirect_pc", redirect_pc, 32'h200);
    checkOutput("mask.mcause", m_cause, 32'h8000000B);
    checkOutput("mask.mepc", m_epc, 32'h800);
    checkOutput("busy.write_dropped", m_scratch, 32'h1111);
    irq_meip = 1'b0;

    // Reset in W_MCAUSE aborts: mepc already written, mcause untouched, no redirect.
    coreWrite(12'h300, 32'h8);
    coreWrite(12'h305, 32'h200);
    exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h900; exc_tval = 32'h77;
    @(posedge ctrl_clk);
    @(negedge ctrl_clk);
    exc_valid = 1'b0;
    @(negedge ctrl_clk);
    checkOutput("abort.busy_before", {31'd0, busy}, 32'd1);
    ctrl_reset = 1'b1;
    #1;
    checkOutput("abort.busy", {31'd0, busy}, 32'd0);
    checkOutput("abort.csr_wen", {31'd0, csr_wen}, 32'd0);
    @(negedge ctrl_clk);
    checkOutput("abort.mepc", m_epc, 32'h900);
    checkOutput("abort.mcause", m_cause, 32'h8000000B);
    checkOutput("abort.mstatus", m_status, 32'h8);
    ctrl_reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge ctrl_clk);
      seen = seen | busy | redirect_valid;
    end
    checkOutput("abort.no_redirect", {31'd0, seen}, 32'd0);
    rv = '{1'b1, 4'd6, 32'hA00, 32'h1, 3'b000, 32'h0, 1'b0, 32'h0, 32'h8, 32'h200, 32'h0,
           32'hA00, 32'h6, 32'h1, 32'h80, 32'h200, 6};
    applyStimulus(rv, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer sitting directly upstream of the CSR file: the only master of the CSR file's single `addr`/`wdata`/`wen` port. It passes core CSR-instruction accesses through while idle. On an exception, pending enabled interrupt or `mret`, it takes the port and runs a fixed write/read sequence (`mepc`, `mcause`, `mtval`, `mstatus`, `mtvec` / `mepc`). It then issues a one-cycle PC redirect to fetch. RV32, M-mode only, hart 0.

## Interface
Parameters:
- `VECTORED_EN`, default 1: honour `mtvec` mode 1 (vectored) for interrupts. When 0, mode is treated as direct.

Ports:
- `ctrl_clk` in 1: clock, rising edge.
- `ctrl_reset` in 1: reset; one clock; asynchronous, active-high.
- `exc_valid` in 1: synchronous exception request.
- `exc_cause` in 4: exception code, 0–15.
- `exc_pc` in 32: PC of the faulting instruction.
- `exc_tval` in 32: bad address/instruction.
- `mret_valid` in 1: `mret` retiring.
- `irq_msip`, `irq_mtip`, `irq_meip` in 1 each: raw interrupt lines, level.
- `irq_pc` in 32: PC to resume at after an interrupt.
- `core_csr_addr` in 12, `core_csr_wdata` in 32, `core_csr_wen` in 1: core CSR access.
- `core_csr_rdata` out 32: CSR read data returned to the core.
- `csr_addr` out 12, `csr_wdata` out 32, `csr_wen` out 1: to the CSR file.
- `csr_rdata` in 32: combinational read data from the CSR file.
- `ctrl_mie`, `ctrl_mpie` in 1: `mstatus.MIE` / `mstatus.MPIE` from the CSR file.
- `busy` out 1: sequence in progress; the core must stall.
- `redirect_valid` out 1: one-cycle pulse.
- `redirect_pc` out 32: new PC, valid while `redirect_valid` is high.

## Operation
- **States:** IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTAT, R_MTVEC, M_STAT, R_MEPC. `busy` = (state ≠ IDLE).
- **IDLE passthrough:** `csr_*` = `core_csr_*`. `core_csr_rdata` = `csr_rdata`. Outside IDLE, core writes are dropped and `core_csr_rdata` = 0.
- **Shadow mie:** the block keeps a 3-bit shadow of `mie` bits 11, 7 and 3. It is updated on any passthrough write with `core_csr_addr` = 0x304; reset value 0.
- **Interrupt pending:** `irq_req` = `ctrl_mie` & |(lines & shadow).
- **Interrupt priority:** MEI (cause 11) > MSI (3) > MTI (7).
- **Acceptance in IDLE:** priority is `exc_valid` > `irq_req` > `mret_valid`. Losers are ignored; the requester holds its request until `redirect_valid`. On accept, latch: cause, the interrupt flag, PC (`exc_pc` or `irq_pc`) and tval (`exc_tval`, or 0 for an interrupt).
- **Trap path:**
  - W_MEPC: write 0x341 ← {pc[31:2], 2'b00}.
  - W_MCAUSE: write 0x342 ← {irq, 27'b0, cause}.
  - W_MTVAL: write 0x343 ← tval.
  - W_MSTAT: addr 0x300, write `csr_rdata` with bit 7 ← `csr_rdata`[3] and bit 3 ← 0 (same-cycle read-modify-write).
  - R_MTVEC: addr 0x305, `wen` = 0. base = {rdata[31:2], 2'b00}. Target = base + 4·cause if `VECTORED_EN` && rdata[1:0] = 1 && irq; otherwise base. Target and the pulse are registered, then return to IDLE.
- **mret path:**
  - M_STAT: addr 0x300, write `csr_rdata` with bit 3 ← bit 7 and bit 7 ← 1.
  - R_MEPC: addr 0x341, target = {rdata[31:2], 2'b00}, then return to IDLE.
- **Target arithmetic:** 32-bit, wraps modulo 2^32.

## Timing
- **Reset values:** state IDLE; `busy` 0; `redirect_valid` 0; `redirect_pc` 0; shadow 0. `csr_wen` is forced 0 while `ctrl_reset` is high.
- **Reset mid-sequence:** aborts immediately. No further CSR writes, no redirect. Partial CSR updates remain.
- **Trap latency:** accept at edge of cycle T. W_MEPC…R_MTVEC occupy T+1..T+5. `redirect_valid` is high in T+6, with state already IDLE. `busy` is high T+1..T+5.
- **mret latency:** M_STAT in T+1, R_MEPC in T+2, `redirect_valid` in T+3.
- **Accept-cycle CSR write:** a core write in the accept cycle T is still passed through. A write to `mie` or `mstatus` in T affects the CSR file before W_MSTAT. Interrupt evaluation in T uses the pre-write shadow.
- **Back-to-back:** a new request may be accepted in the `redirect_valid` cycle.
- **Nested interrupts:** interrupts are not re-taken while `ctrl_mie` = 0 after W_MSTAT.

## Test plan
- **Illegal-instruction trap:** `exc_valid`, cause 2, pc 0x104, tval 0xDEADBEEF, `mtvec` 0x200, MIE 1. Required: writes `mepc` 0x104, `mcause` 2, `mtval` 0xDEADBEEF, `mstatus` MPIE 1 / MIE 0. Redirect 0x200 at T+6.
- **Vectored timer interrupt:** shadow MTIE set, MIE 1, `irq_mtip`, `mtvec` 0x301. Required: `mcause` 0x80000007, `mtval` 0, redirect 0x31C.
- **mret:** `mstatus` MPIE 1 / MIE 0, `mepc` 0x104. Required: `mstatus` MIE 1 / MPIE 1, redirect 0x104 at T+3.
- **Simultaneous requests:** `exc_valid` cause 8 plus `irq_meip` enabled. Required: exception taken, `mcause` 8. After redirect, MIE = 0 so no interrupt is taken.
- **Disabled interrupt:** `irq_meip` with shadow MEIE 0 → no trap, `busy` stays 0. A core write of `mie` 0x800 → trap `mcause` 0x8000000B on the next cycle.
- **Reset mid-sequence:** assert `ctrl_reset` in W_MCAUSE. Required: `busy` 0 and `csr_wen` 0 immediately, no `redirect_valid`. The first request after release is serviced normally.
